uart_cmd_ctrl: RTL

- Command sequencer between the UART receiver/transmitter pair and the modem datapath inside main.
- Collects 4-byte command frames from the UART RX byte stream: opcode, payload hi, payload lo, terminator.
- Updates the datapath configuration registers (mode, frame length), starts a datapath run and waits for it to finish.
- Returns exactly one status/ack byte per accepted frame through the UART TX handshake.

---
 rtl/uart_cmd_ctrl_if.sv | 34 +++
 rtl/uart_cmd_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between uart_cmd_ctrl, the UART RX/TX pair and the modem datapath.
//
// Handshake semantics: every *_dv / *_done / *_start signal is a one-cycle
// strobe. A strobe carries its data (rx_byte, tx_byte) in the same cycle.
// tx_byte stays stable from the tx_dv cycle until tx_done. tx_busy and
// dp_busy are level "not ready" indications. tx_dv is only raised while
// tx_busy is low. There is no back-pressure on rx_dv: bytes that arrive
// when the controller cannot use them are dropped and flagged on err_pulse.
interface uart_cmd_ctrl_if;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len;
  logic        dp_start;
  logic        dp_busy;
  logic        dp_done;
  logic        ctrl_busy;
  logic        err_pulse;
  logic [2:0]  dbg_state;

  modport slave (
    input  rx_dv, rx_byte, tx_busy, tx_done, dp_busy, dp_done,
    output tx_dv, tx_byte, cfg_mode, cfg_len, dp_start, ctrl_busy, err_pulse, dbg_state
  );

  modport master (
    output rx_dv, rx_byte, tx_busy, tx_done, dp_busy, dp_done,
    input  tx_dv, tx_byte, cfg_mode, cfg_len, dp_start, ctrl_busy, err_pulse, dbg_state
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: collects 4-byte frames (opcode, hi, lo, terminator) from
// UART RX, updates datapath config, optionally runs the datapath, and returns
// exactly one reply byte per accepted frame through UART TX.
module uart_cmd_ctrl #(
  parameter int          TIMEOUT_CLKS = 3480,
  parameter logic [15:0] DEFAULT_LEN  = 16'd16,
  parameter logic [7:0]  TERM_BYTE    = 8'hFF
) (
  input  logic           in_clk,
  input  logic           in_reset,
  uart_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_HI, S_GET_LO, S_GET_TERM, S_EXEC, S_WAIT_DP, S_SEND, S_WAIT_TX
  } state_t;

  localparam int            CW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    R_ACK    = 8'hA5;
  localparam logic [7:0]    R_NAK    = 8'h5A;
  localparam logic [7:0]    R_DONE   = 8'hD0;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [7:0]     r_op, r_hi, r_lo, r_term;
  logic [7:0]     r_tx_byte;
  logic [1:0]     r_cfg_mode;
  logic [15:0]    r_cfg_len;
  logic           r_dp_start;
  logic           r_err;

  state_t         w_state_nxt;
  logic           w_in_frame;
  logic           w_cnt_last;
  logic           w_load_tx;
  logic [7:0]     w_tx_byte_nxt;
  logic           w_set_mode;
  logic           w_set_len;
  logic           w_start;
  logic           w_err;
  logic           w_tx_dv;

  assign w_in_frame = (r_state == S_GET_HI) || (r_state == S_GET_LO) || (r_state == S_GET_TERM);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Next-state and per-cycle control decisions; EXEC evaluates the frame.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_tx     = 1'b0;
    w_tx_byte_nxt = r_tx_byte;
    w_set_mode    = 1'b0;
    w_set_len     = 1'b0;
    w_start       = 1'b0;
    w_err         = 1'b0;
    w_tx_dv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_dv) w_state_nxt = S_GET_HI;
      end
      S_GET_HI, S_GET_LO, S_GET_TERM: begin
        // A byte arriving on the expiry cycle still counts.
        if (bus.rx_dv) begin
          w_state_nxt = state_t'(r_state + 3'd1);
        end else if (w_cnt_last) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end
      end
      S_EXEC: begin
        w_err         = bus.rx_dv;
        w_load_tx     = 1'b1;
        w_state_nxt   = S_SEND;
        w_tx_byte_nxt = R_NAK;
        if (r_term != TERM_BYTE) begin
          w_err = 1'b1;
        end else begin
          case (r_op)
            8'h01: begin
              w_set_mode    = 1'b1;
              w_tx_byte_nxt = R_ACK;
            end
            8'h02: begin
              if ({r_hi, r_lo} == 16'h0000) begin
                w_err = 1'b1;
              end else begin
                w_set_len     = 1'b1;
                w_tx_byte_nxt = R_ACK;
              end
            end
            8'h03: begin
              if ((r_cfg_len == 16'h0000) || bus.dp_busy) begin
                w_err = 1'b1;
              end else begin
                w_start     = 1'b1;
                w_load_tx   = 1'b0;
                w_state_nxt = S_WAIT_DP;
              end
            end
            8'h04: begin
              w_tx_byte_nxt = {4'hC, 1'b0, bus.dp_busy, r_cfg_mode};
            end
            default: begin
              w_err = 1'b1;
            end
          endcase
        end
      end
      S_WAIT_DP: begin
        w_err = bus.rx_dv;
        if (bus.dp_done) begin
          w_load_tx     = 1'b1;
          w_tx_byte_nxt = R_DONE;
          w_state_nxt   = S_SEND;
        end
      end
      S_SEND: begin
        w_err = bus.rx_dv;
        if (!bus.tx_busy) begin
          w_tx_dv     = 1'b1;
          w_state_nxt = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        w_err = bus.rx_dv;
        if (bus.tx_done) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Inter-byte timeout counter: runs only while a frame is being collected.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset)                                  r_cnt <= '0;
    else if (w_in_frame && !bus.rx_dv && !w_cnt_last) r_cnt <= r_cnt + 1'b1;
    else                                           r_cnt <= '0;
  end

  // Frame byte capture, one byte per collection state.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_op   <= 8'h00;
      r_hi   <= 8'h00;
      r_lo   <= 8'h00;
      r_term <= 8'h00;
    end else if (bus.rx_dv) begin
      if (r_state == S_IDLE)     r_op   <= bus.rx_byte;
      if (r_state == S_GET_HI)   r_hi   <= bus.rx_byte;
      if (r_state == S_GET_LO)   r_lo   <= bus.rx_byte;
      if (r_state == S_GET_TERM) r_term <= bus.rx_byte;
    end
  end

  // Config registers, reply byte and single-cycle pulses.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_tx_byte  <= 8'h00;
      r_cfg_mode <= 2'd0;
      r_cfg_len  <= DEFAULT_LEN;
      r_dp_start <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_load_tx)  r_tx_byte  <= w_tx_byte_nxt;
      if (w_set_mode) r_cfg_mode <= r_lo[1:0];
      if (w_set_len)  r_cfg_len  <= {r_hi, r_lo};
      r_dp_start <= w_start;
      r_err      <= w_err;
    end
  end

  assign bus.tx_dv     = w_tx_dv;
  assign bus.tx_byte   = r_tx_byte;
  assign bus.cfg_mode  = r_cfg_mode;
  assign bus.cfg_len   = r_cfg_len;
  assign bus.dp_start  = r_dp_start;
  assign bus.ctrl_busy = (r_state != S_IDLE);
  assign bus.err_pulse = r_err;
  assign bus.dbg_state = r_state;

endmodule
